// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: single-entry stage buffer with valid/ready toward EX,
// load-use bubble insertion and flush. Define PERF_COUNTERS_EN to add event counters.
module id_ex_reg #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic            id_rs1_used,
  input  logic            id_rs2_used,
  input  logic [3:0]      id_alu_control,
  input  logic [1:0]      id_mem_to_reg,
  input  logic            id_reg_write,
  input  logic            id_operand_a,
  input  logic            id_operand_b,
  input  logic            id_load,
  input  logic            id_store,
  input  logic            id_branch,
  input  logic            id_jal,
  input  logic            id_jalr,
  input  logic [2:0]      id_fun3,
  input  logic            flush,
  input  logic            ex_ready,
`ifdef PERF_COUNTERS_EN
  output logic [31:0]     bubble_cnt,
  output logic [31:0]     flush_cnt,
  output logic [31:0]     stall_cnt,
`endif
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [3:0]      ex_alu_control,
  output logic [1:0]      ex_mem_to_reg,
  output logic            ex_reg_write,
  output logic            ex_operand_a,
  output logic            ex_operand_b,
  output logic            ex_load,
  output logic            ex_store,
  output logic            ex_branch,
  output logic            ex_jal,
  output logic            ex_jalr,
  output logic [2:0]      ex_fun3
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [3:0]      alu_control;
    logic [1:0]      mem_to_reg;
    logic            reg_write;
    logic            operand_a;
    logic            operand_b;
    logic            load;
    logic            store;
    logic            branch;
    logic            jal;
    logic            jalr;
    logic [2:0]      fun3;
  } payload_t;

  payload_t r_ex;
  payload_t w_id;
  logic     r_valid;
  logic     w_adv;
  logic     w_hz;

  assign w_id = '{
    pc: id_pc, rs1_data: id_rs1_data, rs2_data: id_rs2_data, imm: id_imm,
    rs1: id_rs1, rs2: id_rs2, rd: id_rd, alu_control: id_alu_control,
    mem_to_reg: id_mem_to_reg, reg_write: id_reg_write, operand_a: id_operand_a,
    operand_b: id_operand_b, load: id_load, store: id_store, branch: id_branch,
    jal: id_jal, jalr: id_jalr, fun3: id_fun3
  };

  assign w_adv = ~r_valid | ex_ready;

  // A load into x0 never produces a value worth waiting for.
  assign w_hz = id_valid & r_valid & r_ex.load & (r_ex.rd != 5'd0) &
                ((id_rs1_used & (id_rs1 == r_ex.rd)) |
                 (id_rs2_used & (id_rs2 == r_ex.rd)));

  assign id_ready = rst_n & (flush | (w_adv & ~w_hz));

  // NOTE: the payload is cleared on reset, flush and bubble (not just ex_valid)
  // so an invalid entry stays inert even if EX ignores ex_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_ex    <= '0;
    end else if (flush || (w_adv && w_hz)) begin
      r_valid <= 1'b0;
      r_ex    <= '0;
    end else if (w_adv) begin
      r_valid <= id_valid;
      r_ex    <= id_valid ? w_id : '0;
    end
  end

`ifdef PERF_COUNTERS_EN
  logic [31:0] r_bubble_cnt;
  logic [31:0] r_flush_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
      r_stall_cnt  <= '0;
    end else begin
      if (!flush && w_adv && w_hz)          r_bubble_cnt <= r_bubble_cnt + 32'd1;
      if (flush && r_valid)                 r_flush_cnt  <= r_flush_cnt + 32'd1;
      if (r_valid && !ex_ready && !flush)   r_stall_cnt  <= r_stall_cnt + 32'd1;
    end
  end

  assign bubble_cnt = r_bubble_cnt;
  assign flush_cnt  = r_flush_cnt;
  assign stall_cnt  = r_stall_cnt;
`endif

  assign ex_valid       = r_valid;
  assign ex_pc          = r_ex.pc;
  assign ex_rs1_data    = r_ex.rs1_data;
  assign ex_rs2_data    = r_ex.rs2_data;
  assign ex_imm         = r_ex.imm;
  assign ex_rs1         = r_ex.rs1;
  assign ex_rs2         = r_ex.rs2;
  assign ex_rd          = r_ex.rd;
  assign ex_alu_control = r_ex.alu_control;
  assign ex_mem_to_reg  = r_ex.mem_to_reg;
  assign ex_reg_write   = r_ex.reg_write;
  assign ex_operand_a   = r_ex.operand_a;
  assign ex_operand_b   = r_ex.operand_b;
  assign ex_load        = r_ex.load;
  assign ex_store       = r_ex.store;
  assign ex_branch      = r_ex.branch;
  assign ex_jal         = r_ex.jal;
  assign ex_jalr        = r_ex.jalr;
  assign ex_fun3        = r_ex.fun3;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: accepted instructions are queued on a scoreboard
// and popped when they appear on ex_*; stalls, bubbles, flush and reset are checked.
module tb_id_ex_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_rs1_used, id_rs2_used;
  logic [3:0]  id_alu_control;
  logic [1:0]  id_mem_to_reg;
  logic        id_reg_write, id_operand_a, id_operand_b, id_load, id_store;
  logic        id_branch, id_jal, id_jalr;
  logic [2:0]  id_fun3;
  logic        flush, ex_ready;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_alu_control;
  logic [1:0]  ex_mem_to_reg;
  logic        ex_reg_write, ex_operand_a, ex_operand_b, ex_load, ex_store;
  logic        ex_branch, ex_jal, ex_jalr;
  logic [2:0]  ex_fun3;
`ifdef PERF_COUNTERS_EN
  logic [31:0] bubble_cnt, flush_cnt, stall_cnt;
`endif

  id_ex_reg #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_alu_control(id_alu_control), .id_mem_to_reg(id_mem_to_reg),
    .id_reg_write(id_reg_write), .id_operand_a(id_operand_a), .id_operand_b(id_operand_b),
    .id_load(id_load), .id_store(id_store), .id_branch(id_branch),
    .id_jal(id_jal), .id_jalr(id_jalr), .id_fun3(id_fun3),
    .flush(flush), .ex_ready(ex_ready),
`ifdef PERF_COUNTERS_EN
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt), .stall_cnt(stall_cnt),
`endif
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_alu_control(ex_alu_control), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_reg_write(ex_reg_write), .ex_operand_a(ex_operand_a), .ex_operand_b(ex_operand_b),
    .ex_load(ex_load), .ex_store(ex_store), .ex_branch(ex_branch),
    .ex_jal(ex_jal), .ex_jalr(ex_jalr), .ex_fun3(ex_fun3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, rs1_data, rs2_data, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu;
    logic [1:0]  m2r;
    logic        reg_write, load, store;
    logic [2:0]  fun3;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one decoded instruction; datapath fields are derived from the PC.
  task automatic set_instr(input logic [31:0] pc, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic rs1_used,
                           input logic [4:0] rs2, input logic rs2_used,
                           input logic load, input logic [3:0] alu);
    id_valid       = 1'b1;
    id_pc          = pc;
    id_rs1_data    = pc + 32'h1000;
    id_rs2_data    = pc + 32'h2000;
    id_imm         = pc ^ 32'hFFFF_0000;
    id_rs1         = rs1;
    id_rs2         = rs2;
    id_rd          = rd;
    id_rs1_used    = rs1_used;
    id_rs2_used    = rs2_used;
    id_load        = load;
    id_store       = 1'b0;
    id_reg_write   = 1'b1;
    id_alu_control = alu;
    id_mem_to_reg  = load ? 2'd1 : 2'd0;
    id_fun3        = pc[4:2];
    id_operand_a   = 1'b0;
    id_operand_b   = ~load;
    id_branch      = 1'b0;
    id_jal         = 1'b0;
    id_jalr        = 1'b0;
    #1;
  endtask

  task automatic push_exp();
    exp_t e;
    e.pc = id_pc; e.rs1_data = id_rs1_data; e.rs2_data = id_rs2_data; e.imm = id_imm;
    e.rs1 = id_rs1; e.rs2 = id_rs2; e.rd = id_rd; e.alu = id_alu_control;
    e.m2r = id_mem_to_reg; e.reg_write = id_reg_write; e.load = id_load;
    e.store = id_store; e.fun3 = id_fun3;
    sb.push_back(e);
  endtask

  task automatic cmp_entry(input string tag, input exp_t e);
    check({tag, ".valid"}, 32'(ex_valid), 32'd1);
    check({tag, ".pc"}, ex_pc, e.pc);
    check({tag, ".rs1_data"}, ex_rs1_data, e.rs1_data);
    check({tag, ".rs2_data"}, ex_rs2_data, e.rs2_data);
    check({tag, ".imm"}, ex_imm, e.imm);
    check({tag, ".regs"}, {17'd0, ex_rs1, ex_rs2, ex_rd}, {17'd0, e.rs1, e.rs2, e.rd});
    check({tag, ".ctrl"},
          {19'd0, ex_alu_control, ex_mem_to_reg, ex_reg_write, ex_load, ex_store, ex_fun3},
          {19'd0, e.alu, e.m2r, e.reg_write, e.load, e.store, e.fun3});
  endtask

  task automatic pop_and_check(input string tag);
    n_checks++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL %s.sb: observed empty scoreboard expected an entry", tag);
    end
    if (sb.size() != 0) begin
      last = sb.pop_front();
      cmp_entry(tag, last);
    end
  endtask

  task automatic check_empty_entry(input string tag);
    check({tag, ".valid"}, 32'(ex_valid), 32'd0);
    check({tag, ".ctrl"},
          {25'd0, ex_alu_control, ex_reg_write, ex_load, ex_store},
          32'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    set_instr(32'h0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 4'h0);
    id_valid = 1'b0;
    tick(); tick();
    check_empty_entry("reset");
    check("reset.pc", ex_pc, 32'd0);
    check("reset.imm", ex_imm, 32'd0);
    check("reset.id_ready", 32'(id_ready), 32'd0);
    rst_n = 1'b1; #1;
    check("post_reset.id_ready", 32'(id_ready), 32'd1);

    // Stream of two independent addi instructions.
    set_instr(32'h0, 5'd1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 4'h1);
    check("addi1.id_ready", 32'(id_ready), 32'd1);
    push_exp(); tick();
    pop_and_check("addi1");
    set_instr(32'h4, 5'd2, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 4'h1);
    check("addi2.id_ready", 32'(id_ready), 32'd1);
    push_exp(); tick();
    pop_and_check("addi2");

    // Load-use: lw x5 then add x6,x5,x7.
    set_instr(32'h8, 5'd5, 5'd2, 1'b1, 5'd0, 1'b0, 1'b1, 4'h0);
    push_exp(); tick();
    pop_and_check("lw_x5");
    set_instr(32'hC, 5'd6, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 4'h2);
    check("hz.id_ready", 32'(id_ready), 32'd0);
    tick();
    check_empty_entry("bubble");
`ifdef PERF_COUNTERS_EN
    check("bubble.bubble_cnt", bubble_cnt, 32'd1);
`endif
    check("after_bubble.id_ready", 32'(id_ready), 32'd1);
    push_exp(); tick();
    pop_and_check("add_x6");

    // Load to x0 followed by a reader of x0: no bubble.
    set_instr(32'h10, 5'd0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 4'h0);
    push_exp(); tick();
    pop_and_check("lw_x0");
    set_instr(32'h14, 5'd8, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 4'h3);
    check("x0_dep.id_ready", 32'(id_ready), 32'd1);
    push_exp(); tick();
    pop_and_check("x0_dep");

    // Load x9 followed by an instruction whose unused rs2 field matches.
    set_instr(32'h18, 5'd9, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 4'h0);
    push_exp(); tick();
    pop_and_check("lw_x9");
    set_instr(32'h1C, 5'd11, 5'd3, 1'b1, 5'd9, 1'b0, 1'b0, 4'h4);
    check("rs2_unused.id_ready", 32'(id_ready), 32'd1);
    push_exp(); tick();
    pop_and_check("rs2_unused");

    // Backpressure for three edges: entry holds, ID is not accepted.
    ex_ready = 1'b0;
    set_instr(32'h20, 5'd10, 5'd4, 1'b1, 5'd0, 1'b0, 1'b1, 4'h0);
    check("stall.id_ready", 32'(id_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      cmp_entry("stall_hold", last);
      check("stall_hold.id_ready", 32'(id_ready), 32'd0);
    end
`ifdef PERF_COUNTERS_EN
    check("stall.stall_cnt", stall_cnt, 32'd3);
`endif
    ex_ready = 1'b1; #1;
    check("release.id_ready", 32'(id_ready), 32'd1);
    push_exp(); tick();
    pop_and_check("lw_x10");

    // Flush while FULL, stalled and hazarded: flush wins.
    ex_ready = 1'b0; flush = 1'b1;
    set_instr(32'h24, 5'd12, 5'd10, 1'b1, 5'd0, 1'b0, 1'b0, 4'h5);
    check("flush.id_ready", 32'(id_ready), 32'd1);
    tick();
    check_empty_entry("flush");
    check("flush.pc", ex_pc, 32'd0);
`ifdef PERF_COUNTERS_EN
    check("flush.flush_cnt", flush_cnt, 32'd1);
    check("flush.stall_cnt", stall_cnt, 32'd3);
    check("flush.bubble_cnt", bubble_cnt, 32'd1);
`endif

    // Refill, then reset while stalled.
    flush = 1'b0; ex_ready = 1'b1;
    set_instr(32'h28, 5'd13, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 4'h6);
    push_exp(); tick();
    pop_and_check("refill");
    ex_ready = 1'b0; id_valid = 1'b0;
    tick();
    cmp_entry("pre_reset_hold", last);
    rst_n = 1'b0;
    tick();
    check_empty_entry("mid_stall_reset");
    check("mid_stall_reset.pc", ex_pc, 32'd0);
    check("mid_stall_reset.rs1_data", ex_rs1_data, 32'd0);
    check("mid_stall_reset.rd", 32'(ex_rd), 32'd0);
    check("mid_stall_reset.id_ready", 32'(id_ready), 32'd0);
`ifdef PERF_COUNTERS_EN
    check("mid_stall_reset.cnts", bubble_cnt | flush_cnt | stall_cnt, 32'd0);
`endif
    rst_n = 1'b1;
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_reg.md
# id_ex_reg

ID/EX pipeline register for the RV32I five-stage core. It sits directly downstream of the ALU decoder and register-file read. It captures decoded control, operands, immediate, PC and register indices into a single-entry stage buffer with a valid/ready handshake toward EX. It inserts a one-cycle bubble on load-use hazards and drops its contents on a branch/jump flush.

## Interface
Parameters:
- XLEN, 32, datapath width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- id_valid  in  1  ID holds a valid decoded instruction
- id_ready  out  1  stage accepts the ID instruction this cycle (combinational)
- id_pc  in  XLEN  instruction PC
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_imm  in  XLEN  generated immediate
- id_rs1, id_rs2, id_rd  in  5  register indices
- id_rs1_used, id_rs2_used  in  1  instruction reads rs1/rs2
- id_alu_control  in  4  ALU operation
- id_mem_to_reg  in  2  writeback select
- id_reg_write, id_operand_a, id_operand_b, id_load, id_store, id_branch, id_jal, id_jalr  in  1  decoded control
- id_fun3  in  3  funct3, used for branch and memory size
- flush  in  1  EX redirect (taken branch, jal, jalr)
- ex_ready  in  1  EX consumes the current entry
- ex_valid  out  1  entry valid
- ex_* (pc, rs1_data, rs2_data, imm, rs1, rs2, rd, alu_control, mem_to_reg, reg_write, operand_a, operand_b, load, store, branch, jal, jalr, fun3)  out  same widths  registered payload

## Operation
- State: the single register ex_valid (EMPTY=0, FULL=1). The payload register holds data only when FULL.
- adv = ~ex_valid | ex_ready. The entry may be replaced this cycle when adv is high.
- hz (load-use) = id_valid & ex_valid & ex_load & (ex_rd≠0) & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
- Priority at each clock edge:
  1. rst_n=0: everything is cleared.
  2. flush: ex_valid←0 and control is cleared. id_ready=1, so the ID instruction is consumed and discarded.
  3. adv & hz: bubble. ex_valid←0 and control is cleared. id_ready=0.
  4. adv & id_valid: load the payload and set ex_valid←1.
  5. adv & ~id_valid: ex_valid←0.
  6. ~adv: hold all outputs unchanged.
- id_ready = flush | (adv & ~hz).
- "Control cleared" means reg_write, load, store, branch, jal and jalr are 0 and alu_control=0. Datapath fields are don't-care but are driven to 0. Invalid entries are therefore inert even if EX ignores ex_valid.
- Combinational path: ex_ready → id_ready. There is no path from id_valid to id_ready except through hz.
- The x0 destination never triggers hz.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N appears on ex_* after edge N.
- Full throughput is 1 instruction/cycle when ex_ready=1 and there is no hazard or flush.
- A load-use pair costs exactly 1 bubble cycle. After the bubble ex_valid=0, hz deasserts, and the dependent instruction loads on the next edge.
- Reset values: all ex_* outputs are 0 and ex_valid=0. id_ready is 0 during reset and follows the formula after reset.
- Reset asserted mid-stall discards the held entry at that edge.
- flush coincident with hz or ~ex_ready: flush wins, and the entry is dropped even though EX did not accept it.

## Configuration
- PERF_COUNTERS_EN defined: adds outputs bubble_cnt, flush_cnt and stall_cnt, each 32 bits, reset to 0, wrapping modulo 2^32.
  - bubble_cnt increments on each hz bubble edge.
  - flush_cnt increments on each flush edge where ex_valid=1.
  - stall_cnt increments on each edge with ex_valid & ~ex_ready & ~flush.
- PERF_COUNTERS_EN undefined: these ports and their logic are absent, and all other behaviour is identical.

## Test plan
- Stream: addi x1 (pc 0x0), addi x2 (pc 0x4), both with id_valid=1 and ex_ready=1. ex_pc reads 0x0 then 0x4 on consecutive cycles, ex_valid=1, and id_ready stays 1.
- Load-use: lw x5 followed by add x6,x5,x7 (rs1_used=1). Cycle after the lw is in EX: id_ready=0 and ex_valid→0 (bubble, bubble_cnt=1). Next edge the add loads with ex_rd=6.
- Load to x0, or a dependent instruction with rs2_used=0 and matching rs2: no bubble, id_ready=1.
- Backpressure: ex_ready=0 for 3 cycles with a FULL entry. All ex_* outputs hold and id_ready=0 (stall_cnt=3). Releasing ex_ready advances on the next edge.
- Flush with ex_valid=1, ex_ready=0 and hz=1: next edge ex_valid=0, ex_reg_write=0, id_ready=1 that cycle, flush_cnt=1.
- rst_n=0 for one edge while FULL: all ex_* outputs are 0 and ex_valid=0 after that edge.
